// File: rtl/pipe_reg_chain_if.sv
// Handshake bundle for the register chain: upstream push side and downstream pop side.
// Latency: none, wires only.
// Backpressure: in_ready / out_ready carry stall information in each direction.
interface pipe_reg_chain_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // Environment side: produces input words and consumes output words.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // Chain side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/pipe_reg_chain.sv
// Bubble-collapsing chain of DEPTH valid/data register stages with occupancy count.
// Latency: DEPTH cycles from input acceptance to out_valid on an empty chain.
// Backpressure: combinational ready ripple; an empty stage accepts even while later stages stall.
module pipe_reg_chain #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              OCC_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    pipe_reg_chain_if.slave    bus,
    output logic [OCC_W-1:0]   occupancy
);

    logic [DEPTH-1:0]            v_q, v_d;
    logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
    logic [OCC_W-1:0]            occ_q, occ_d;

    logic [DEPTH-1:0]            rdy;
    logic                        tail_full;
    logic [DEPTH-1:0]            src_v;
    logic [DEPTH-1:0][WIDTH-1:0] src_d;
    logic                        in_rdy;
    logic                        in_xfer;
    logic                        out_vld;
    logic                        out_xfer;

    // Stage ready: a stage can load when downstream pops or any stage from here to the output is empty.
    always_comb begin
        rdy       = '0;
        tail_full = 1'b1;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            tail_full = tail_full & v_q[k];
            rdy[k]    = !tail_full | bus.out_ready;
        end
    end

    // Boundary handshakes; flush and reset block both transfers.
    always_comb begin
        in_rdy   = rdy[0] & !flush & !reset;
        out_vld  = v_q[DEPTH-1] & !flush;
        in_xfer  = bus.in_valid & in_rdy;
        out_xfer = out_vld & bus.out_ready;
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = d_q[DEPTH-1];
    assign occupancy     = occ_q;

    // Upstream source of each stage: stage 0 takes the accepted input, others the previous stage.
    always_comb begin
        src_v    = '0;
        src_d    = '0;
        src_v[0] = in_xfer;
        src_d[0] = bus.in_data;
        for (int k = 1; k < DEPTH; k++) begin
            src_v[k] = v_q[k-1];
            src_d[k] = d_q[k-1];
        end
    end

    // Next stage contents and occupancy; flush clears everything, otherwise ready stages advance.
    always_comb begin
        v_d   = v_q;
        d_d   = d_q;
        occ_d = occ_q;
        if (flush) begin
            v_d   = '0;
            occ_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_d[k] = RST_VAL;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    v_d[k] = src_v[k];
                    // Data only moves with a valid word; a bubble leaves the old value in place.
                    if (src_v[k]) begin
                        d_d[k] = src_d[k];
                    end
                end
            end
            case ({in_xfer, out_xfer})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= RST_VAL;
            end
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            occ_q <= occ_d;
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain with a slot-level reference model and per-cycle compare.
// Latency: n/a.
// Backpressure: drives out_ready directly from the directed sequences.
module tb_pipe_reg_chain;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic [2:0]   occupancy;

    pipe_reg_chain_if #(.WIDTH(W)) bus ();

    pipe_reg_chain #(
        .WIDTH   (W),
        .DEPTH   (D),
        .RST_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;
    int cycle = 0;

    // Reference: slot array, words move forward unless part of the stalled block at the output.
    logic       mv [D] = '{default: 1'b0};
    logic [7:0] md [D] = '{default: 8'h00};

    logic [7:0] outq[$];
    int         outcyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int k = 0; k < D; k++) n += int'(mv[k]);
        return n;
    endfunction

    function automatic logic m_in_ready();
        return ((m_count() < D) || bus.out_ready) && !flush && !reset;
    endfunction

    // Model update on each rising edge.
    always @(posedge clk) begin : model
        logic       ov [D];
        logic [7:0] od [D];
        logic       ixf;
        int         hold_from;
        cycle++;
        ixf = bus.in_valid && m_in_ready();
        if (reset || flush) begin
            for (int k = 0; k < D; k++) begin
                mv[k] = 1'b0;
                md[k] = 8'h00;
            end
        end else begin
            ov = mv;
            od = md;
            hold_from = D;
            if (!bus.out_ready) begin
                while (hold_from > 0 && ov[hold_from-1]) hold_from--;
            end
            for (int k = 0; k < hold_from; k++) begin
                if (k == 0) begin
                    mv[0] = ixf;
                    if (ixf) md[0] = bus.in_data;
                end else begin
                    mv[k] = ov[k-1];
                    if (ov[k-1]) md[k] = od[k-1];
                end
            end
        end
    end

    // Mid-cycle compare against the model and capture of output transfers.
    always @(negedge clk) begin
        if (started) begin
            chk("model out_valid", 32'(bus.out_valid), 32'(mv[D-1] && !flush));
            chk("model out_data",  32'(bus.out_data),  32'(md[D-1]));
            chk("model occupancy", 32'(occupancy),     32'(m_count()));
            chk("model in_ready",  32'(bus.in_ready),  32'(m_in_ready()));
            if (bus.out_valid && bus.out_ready) begin
                outq.push_back(bus.out_data);
                outcyc.push_back(cycle);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push3();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data = 8'hA1; cyc();
        bus.in_data = 8'hA2; cyc();
        bus.in_data = 8'hA3; cyc();
        chk("pre-clear occupancy", 32'(occupancy), 32'd3);
    endtask

    task automatic clear_test(input bit use_rst);
        push3();
        bus.in_data = 8'hEE;
        if (use_rst) reset = 1'b1; else flush = 1'b1;
        #1;
        chk("clear in_ready", 32'(bus.in_ready), 32'd0);
        if (!use_rst) chk("flush out_valid gated", 32'(bus.out_valid), 32'd0);
        cyc();
        reset = 1'b0;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("clear occupancy", 32'(occupancy), 32'd0);
        chk("clear out_valid", 32'(bus.out_valid), 32'd0);
        chk("clear out_data",  32'(bus.out_data), 32'h00);
        chk("clear in_ready",  32'(bus.in_ready), 32'd1);
        for (int i = 0; i < D + 1; i++) begin
            cyc();
            chk("cleared word never exits", 32'(bus.out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] exp_fill [5];
        exp_fill = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        cyc();
        started = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset out_data",  32'(bus.out_data), 32'h00);
        chk("reset occupancy", 32'(occupancy), 32'd0);
        chk("reset in_ready",  32'(bus.in_ready), 32'd1);

        // Single-word latency.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hA5;
        #1 chk("latency in_ready", 32'(bus.in_ready), 32'd1);
        cyc();
        bus.in_valid = 1'b0;
        for (int i = 1; i <= D; i++) begin
            chk("latency occupancy", 32'(occupancy), 32'd1);
            chk("latency out_valid", 32'(bus.out_valid), 32'(i == D));
            if (i == D) chk("latency out_data", 32'(bus.out_data), 32'hA5);
            cyc();
        end
        chk("latency drained occupancy", 32'(occupancy), 32'd0);
        chk("latency drained out_valid", 32'(bus.out_valid), 32'd0);

        // Streaming 0x01..0x10.
        outq.delete();
        outcyc.delete();
        for (int i = 1; i <= 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            #1 chk("stream in_ready", 32'(bus.in_ready), 32'd1);
            cyc();
        end
        bus.in_valid = 1'b0;
        repeat (D + 2) cyc();
        chk("stream count", 32'(outq.size()), 32'd16);
        if (outq.size() == 16) begin
            for (int i = 0; i < 16; i++) chk("stream order", 32'(outq[i]), 32'(i + 1));
            chk("stream back-to-back", 32'(outcyc[15] - outcyc[0]), 32'd15);
        end

        // Fill under stall, refuse a fifth word.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = exp_fill[i];
            cyc();
        end
        bus.in_data = 8'h99;
        #1;
        chk("full occupancy", 32'(occupancy), 32'd4);
        chk("full in_ready",  32'(bus.in_ready), 32'd0);
        cyc();
        chk("fifth word refused", 32'(occupancy), 32'd4);
        chk("full head data", 32'(bus.out_data), 32'h11);

        // Full with simultaneous push and pop.
        outq.delete();
        bus.in_data   = 8'h55;
        bus.out_ready = 1'b1;
        #1;
        chk("simul in_ready",  32'(bus.in_ready), 32'd1);
        chk("simul out_valid", 32'(bus.out_valid), 32'd1);
        cyc();
        chk("simul occupancy", 32'(occupancy), 32'd4);
        chk("simul next head", 32'(bus.out_data), 32'h22);
        bus.in_valid = 1'b0;
        repeat (D + 1) cyc();
        chk("drain count", 32'(outq.size()), 32'd5);
        if (outq.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("drain order", 32'(outq[i]), 32'(exp_fill[i]));
        end

        // Bubble collapse.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h66;
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        cyc();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        cyc();
        bus.in_valid = 1'b0;
        repeat (3) cyc();
        chk("bubble occupancy", 32'(occupancy), 32'd2);
        chk("bubble head", 32'(bus.out_data), 32'h66);
        outq.delete();
        outcyc.delete();
        bus.out_ready = 1'b1;
        cyc();
        chk("bubble second valid", 32'(bus.out_valid), 32'd1);
        chk("bubble second data",  32'(bus.out_data), 32'h77);
        cyc();
        chk("bubble drained", 32'(bus.out_valid), 32'd0);
        chk("bubble pop count", 32'(outq.size()), 32'd2);
        if (outq.size() == 2) begin
            chk("bubble first out", 32'(outq[0]), 32'h66);
            chk("bubble second out", 32'(outq[1]), 32'h77);
            chk("bubble back-to-back", 32'(outcyc[1] - outcyc[0]), 32'd1);
        end

        // Flush, then the same with reset.
        clear_test(1'b0);
        clear_test(1'b1);

        started = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 Parameter: WIDTH, default 8, data width in bits; legal range 1 or more.
REQ-002 Parameter: DEPTH, default 4, number of register stages; legal range 1 or more.
REQ-003 Parameter: RST_VAL, default 0 (WIDTH bits), value loaded into every stage data register on reset and flush.
REQ-004 Port: clk, input, 1, rising-edge clock for all state.
REQ-005 Port: reset, input, 1, synchronous, active-high.
REQ-006 Port: flush, input, 1, synchronous pipeline clear, active-high.
REQ-007 Port: in_valid, input, 1, upstream data valid.
REQ-008 Port: in_ready, output, 1, chain can accept in_data this cycle.
REQ-009 Port: in_data, input, WIDTH, upstream data.
REQ-010 Port: out_valid, output, 1, last stage holds valid data.
REQ-011 Port: out_ready, input, 1, downstream accepts out_data this cycle.
REQ-012 Port: out_data, output, WIDTH, last stage data register.
REQ-013 Port: occupancy, output, clog2(DEPTH+1), number of stages currently holding valid data.

Function
REQ-014 Each stage k (0..DEPTH-1) SHALL hold a data register d[k] and a valid bit v[k]; stage 0 is the input end and stage DEPTH-1 drives out_data/out_valid.
REQ-015 Stage ready SHALL be rdy[k] = !v[k] | rdy[k+1], with rdy[DEPTH] = out_ready; the path is combinational (bubble-collapsing, no skid buffer).
REQ-016 in_ready SHALL equal rdy[0] & !flush & !reset.
REQ-017 out_valid SHALL equal v[DEPTH-1] & !flush; out_data SHALL equal d[DEPTH-1] at all times.
REQ-018 Transfer rules: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
REQ-019 On an edge with rdy[k]=1, stage k SHALL load from stage k-1 (stage 0 from in_data/in_valid transfer), taking v[k] <= v[k-1] (or the input transfer bit) and d[k] <= d[k-1] only when the incoming valid is 1; otherwise d[k] holds.
REQ-020 On an edge with rdy[k]=0, stage k SHALL hold d[k] and v[k].
REQ-021 Latency: with an empty chain and out_ready=1, data accepted on edge n SHALL appear with out_valid=1 in the cycle after edge n+DEPTH-1, i.e. DEPTH cycles after acceptance.
REQ-022 Throughput: with out_ready held at 1, the chain SHALL accept one word per cycle indefinitely with no bubbles inserted.
REQ-023 Backpressure: with out_ready=0, the chain SHALL absorb words until all DEPTH stages are valid; then in_ready=0 and no data is lost or duplicated.
REQ-024 Bubbles SHALL collapse: an empty stage SHALL accept from upstream even while downstream stages stall.
REQ-025 Full plus simultaneous events: with all stages valid, out_ready=1 and in_valid=1, input and output transfers SHALL both occur on the same edge and occupancy SHALL be unchanged.
REQ-026 Occupancy SHALL be a registered count equal to the sum of v[k]: +1 on input-only transfer, -1 on output-only transfer, unchanged on both or neither transfer.
REQ-027 Flush SHALL take priority over transfers: on an edge with flush=1, all v[k] <= 0, all d[k] <= RST_VAL and occupancy <= 0; no input or output transfer occurs in the flush cycle.
REQ-028 Order SHALL be preserved: words exit in exactly the order accepted.

Reset
REQ-029 On an edge with reset=1: all v[k] <= 0, all d[k] <= RST_VAL and occupancy <= 0; reset overrides flush and all transfers.
REQ-030 After reset: out_valid=0, out_data=RST_VAL, occupancy=0, and in_ready=1 from the first cycle with reset=0 and flush=0.
REQ-031 Reset asserted mid-stream SHALL discard all in-flight words; no word accepted before reset appears at the output afterwards.

Verification (WIDTH=8, DEPTH=4, RST_VAL=0)
REQ-032 Latency: reset, then one word 0xA5 with out_ready=1 -> out_valid=1 and out_data=0xA5 exactly 4 cycles after acceptance; occupancy goes 1,1,1,1 then 0.
REQ-033 Streaming: 0x01..0x10 on consecutive cycles with out_ready=1 -> 16 outputs in order on consecutive cycles; in_ready is never 0.
REQ-034 Fill/stall: out_ready=0, push 0x11,0x22,0x33,0x44 -> occupancy=4, in_ready=0; a fifth word is not accepted; raising out_ready drains 0x11..0x44 in order.
REQ-035 Full simultaneous: chain full, out_ready=1 and in_valid=1 with 0x55 -> 0x11 exits, 0x55 enters on the same edge, occupancy stays 4.
REQ-036 Bubble collapse: out_ready=0, push 0x66 then idle 2 cycles then 0x77 -> occupancy=2 with both words in stages 3 and 2; released in order 0x66, 0x77 back-to-back.
REQ-037 Flush/reset: chain with 3 valid words, flush=1 with in_valid=1 on the same cycle -> next cycle occupancy=0, out_valid=0, out_data=0x00, input word dropped; repeat using reset -> identical result.
